iob_initiator: RTL and testbench
================================

// Module: iob_initiator
//
// PURPOSE
//   Bus initiator for the stb/we/ack IO register bus; drives the same handshake that the
//   IO responders (system control, timers, etc.) answer. Sits between an internal client and the IO bus.
//   Accepts one command (read or write) via valid/ready, issues one bus access, waits for ack
//   with a timeout, and returns read data plus an error flag via valid/ready.
//   Single outstanding transaction. No buffering beyond one command and one response.
//
// PARAMETERS
//   ADDR_W   8    IO bus address width
//   DATA_W   32   IO bus data width (read and write)
//   TIMEOUT  16   cycles stb held without ack before abort; 0 = wait forever
//
// PORTS
//   clk        in   1       system clock, all logic on rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   cmd_valid  in   1       client command present
//   cmd_ready  out  1       initiator can take a command (IDLE only)
//   cmd_we     in   1       1 = write, 0 = read
//   cmd_addr   in   ADDR_W  target register address
//   cmd_wdata  in   DATA_W  write data (ignored for reads)
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       client takes response
//   rsp_rdata  out  DATA_W  read data; 0 for writes and on error
//   rsp_err    out  1       1 = access timed out
//   stb        out  1       bus strobe
//   we         out  1       bus write enable
//   addr       out  ADDR_W  bus address
//   wdata      out  DATA_W  bus write data
//   rdata      in   DATA_W  bus read data (responders drive 0 when not selected)
//   ack        in   1       bus acknowledge; responders may assert combinationally with stb
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; stb, we, addr, wdata, rsp_valid, rsp_err, rsp_rdata all 0;
//     cmd_ready=1 once out of reset. Reset mid-access drops stb immediately; the access is lost, no response.
//   - All bus outputs and rsp_* are registered; cmd_ready = (state==IDLE).
//   - States: IDLE -> REQ -> RESP -> IDLE.
//     IDLE: cmd_valid&cmd_ready captures cmd_*; next cycle state REQ, stb=1, we/addr/wdata from capture.
//     REQ: stb held stable with we/addr/wdata unchanged until ack or timeout.
//       ack=1 at a rising edge: rsp_rdata <= we ? 0 : rdata; rsp_err<=0; stb<=0; -> RESP.
//       no ack: wait counter increments; when TIMEOUT!=0 and counter == TIMEOUT-1 with no ack:
//       rsp_rdata<=0; rsp_err<=1; stb<=0; -> RESP. ack in that same cycle wins (no error).
//     RESP: rsp_valid=1, rsp_* stable until rsp_ready; on rsp_valid&rsp_ready -> IDLE next cycle.
//   - When stb=0: we, addr, wdata driven 0 (OR-bus convention).
//   - Latency with zero-wait responder: command handshake at edge N, stb high cycle N+1,
//     rsp_valid high from N+2. Minimum 3 cycles per transaction (no back-to-back overlap).
//   - Wait counter width $clog2(TIMEOUT+1) (min 1); cleared on entry to REQ; never wraps
//     (TIMEOUT=0: counter held at 0, no abort).
//   - ack or rdata outside REQ: ignored. cmd_valid outside IDLE: not accepted, cmd_* not sampled.
//   - Exactly one stb-high interval per accepted command; no retry after timeout.
//
// STRUCTURE
//   - Package iob_pkg: state enum (IDLE, REQ, RESP), default ADDR_W/DATA_W constants,
//     iob_cmd_t struct {we, addr, wdata} shared with other bus initiators.
//   - One sub-module natural: iob_wait_timer (clear, enable, TIMEOUT param -> expired pulse).
//   - Remainder (FSM, capture regs, response regs) flat in iob_initiator.
//
// TESTING
//   1. Write addr 0x10 data 0x0000_8001, responder acks same cycle as stb -> stb high exactly 1 cycle,
//      we=1, addr=0x10, wdata=0x8001; rsp_valid 2 cycles after cmd handshake, rsp_err=0, rsp_rdata=0.
//   2. Read addr 0x10, responder returns 0x0000_8000 after 3 wait cycles -> stb high 4 cycles, addr stable,
//      rsp_rdata=0x8000, rsp_err=0.
//   3. TIMEOUT=16, no responder -> stb high exactly 16 cycles then 0; rsp_err=1, rsp_rdata=0; a later
//      late ack is ignored and produces no second response.
//   4. rsp_ready held 0 for 10 cycles -> rsp_* stable, cmd_ready=0, stb stays 0, new cmd_valid not taken;
//      rsp_ready=1 -> IDLE, next command accepted on following cycle.
//   5. rst_n asserted while stb=1 in REQ -> stb, rsp_valid drop asynchronously (before next edge); after
//      release cmd_ready=1 and no response issued for the aborted command.
//   6. TIMEOUT=0, ack delayed 100 cycles -> no error, rsp_err=0, read data returned correctly.

Source files
------------

// File: rtl/iob_pkg.sv
// iob_pkg: shared types and defaults for IO register bus initiators.
package iob_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, REQ, RESP} iob_state_t;
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } iob_cmd_t;
  function automatic int cnt_w(input int t);
    return t == 0 ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/iob_wait_timer.sv
// iob_wait_timer: counts enabled cycles and flags the last allowed one; TIMEOUT=0 never expires.
module iob_wait_timer
  import iob_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = cnt_w(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  logic [W-1:0] cnt;
  assign expired = (TIMEOUT != 0) && enable && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear || TIMEOUT == 0) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + W'(1);
endmodule

// File: rtl/iob_initiator.sv
// iob_initiator: single-outstanding stb/we/ack bus initiator with ack timeout,
// command and response exchanged with the client over valid/ready.
module iob_initiator
  import iob_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stb,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ack
);
  iob_state_t state, state_next;
  logic expired, done;
  iob_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk,
    .rst_n,
    .clear  (state != REQ),
    .enable (state == REQ && !ack),
    .expired
  );
  assign cmd_ready = state == IDLE;
  assign done = state == REQ && (ack || expired);
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = cmd_valid ? REQ : IDLE;
      REQ:     state_next = done ? RESP : REQ;
      RESP:    state_next = rsp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end
  // The bus registers double as the command capture; they return to 0 whenever stb drops.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      stb       <= 1'b0;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      rsp_valid <= state_next == RESP;
      if (state == IDLE && cmd_valid) begin
        stb   <= 1'b1;
        we    <= cmd_we;
        addr  <= cmd_addr;
        wdata <= cmd_wdata;
      end
      if (done) begin
        stb       <= 1'b0;
        we        <= 1'b0;
        addr      <= '0;
        wdata     <= '0;
        rsp_rdata <= (ack && !we) ? rdata : '0;
        rsp_err   <= !ack;
      end
      if (state == RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_iob_initiator.sv
// tb_iob_initiator: directed vectors against a TIMEOUT=16 instance (a) and a TIMEOUT=0 instance (b).
module tb_iob_initiator;
  import iob_pkg::*;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic sel = 0, cmd_valid = 0, cmd_we = 0, rsp_ready = 0;
  logic [7:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  int delay = 0, wc = 0;
  logic ack_en = 0, ack_force = 0;
  logic [31:0] rd = 0;
  logic a_cmd_ready, a_rsp_valid, a_rsp_err, a_stb, a_we, a_ack;
  logic b_cmd_ready, b_rsp_valid, b_rsp_err, b_stb, b_we, b_ack;
  logic [31:0] a_rsp_rdata, a_wdata, a_rdata, b_rsp_rdata, b_wdata, b_rdata;
  logic [7:0] a_addr, b_addr;
  logic o_cmd_ready, o_rsp_valid, o_rsp_err, o_stb, o_we;
  logic [31:0] o_rsp_rdata, o_wdata;
  logic [7:0] o_addr;

  iob_initiator #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut_a (
    .clk, .rst_n, .cmd_valid(cmd_valid && !sel), .cmd_ready(a_cmd_ready), .cmd_we, .cmd_addr,
    .cmd_wdata, .rsp_valid(a_rsp_valid), .rsp_ready, .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .stb(a_stb), .we(a_we), .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .ack(a_ack));
  iob_initiator #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(0)) dut_b (
    .clk, .rst_n, .cmd_valid(cmd_valid && sel), .cmd_ready(b_cmd_ready), .cmd_we, .cmd_addr,
    .cmd_wdata, .rsp_valid(b_rsp_valid), .rsp_ready, .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .stb(b_stb), .we(b_we), .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .ack(b_ack));

  assign o_cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign o_stb       = sel ? b_stb       : a_stb;
  assign o_we        = sel ? b_we        : a_we;
  assign o_addr      = sel ? b_addr      : a_addr;
  assign o_wdata     = sel ? b_wdata     : a_wdata;

  // Responder: acks once stb has been high for `delay` earlier cycles; ack_force injects stray acks.
  always @(posedge clk) wc <= o_stb ? wc + 1 : 0;
  assign a_ack = (a_stb && ack_en && wc >= delay) || (ack_force && !sel);
  assign b_ack = (b_stb && ack_en && wc >= delay) || (ack_force && sel);
  assign a_rdata = a_ack ? rd : 32'h0;
  assign b_rdata = b_ack ? rd : 32'h0;

  typedef struct {
    logic        sel;
    iob_cmd_t    cmd;
    int          delay;
    logic        ack_en;
    logic [31:0] rd;
    int          stb_n;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t v);
    int n;
    logic bad;
    sel = v.sel; delay = v.delay; ack_en = v.ack_en; rd = v.rd;
    @(negedge clk);
    chk("cmd_ready_idle", o_cmd_ready, 1);
    cmd_valid = 1; cmd_we = v.cmd.we; cmd_addr = v.cmd.addr; cmd_wdata = v.cmd.wdata;
    @(negedge clk);
    cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0;
    n = 0; bad = 0;
    while (o_stb && n < 300) begin
      if (o_we !== v.cmd.we || o_addr !== v.cmd.addr || (v.cmd.we && o_wdata !== v.cmd.wdata) ||
          o_cmd_ready !== 1'b0 || o_rsp_valid !== 1'b0) bad = 1;
      n++;
      @(negedge clk);
    end
    chk("stb_cycles", n, v.stb_n);
    chk("bus_stable", bad, 0);
    chk("rsp_valid", o_rsp_valid, 1);
    chk("rsp_rdata", o_rsp_rdata, v.exp_rdata);
    chk("rsp_err", o_rsp_err, v.exp_err);
    chk("bus_idle_zero", o_we | (|o_addr) | (|o_wdata), 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_consumed", o_rsp_valid, 0);
    chk("cmd_ready_back", o_cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    vecs[0] = '{1'b0, '{1'b1, 8'h10, 32'h0000_8001}, 0,   1'b1, 32'hFFFF_FFFF, 1,   32'h0,         1'b0};
    vecs[1] = '{1'b0, '{1'b0, 8'h10, 32'h0},         3,   1'b1, 32'h0000_8000, 4,   32'h0000_8000, 1'b0};
    vecs[2] = '{1'b0, '{1'b0, 8'h20, 32'h0},         0,   1'b0, 32'hDEAD_0000, 16,  32'h0,         1'b1};
    vecs[3] = '{1'b0, '{1'b1, 8'h44, 32'hDEAD_BEEF}, 15,  1'b1, 32'h0000_0001, 16,  32'h0,         1'b0};
    vecs[4] = '{1'b0, '{1'b0, 8'h08, 32'h0},         14,  1'b1, 32'hCAFE_F00D, 15,  32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b1, '{1'b0, 8'h7F, 32'h0},         100, 1'b1, 32'h1234_5678, 101, 32'h1234_5678, 1'b0};
    vecs[6] = '{1'b0, '{1'b1, 8'h11, 32'h0000_00A5}, 0,   1'b0, 32'h0,         16,  32'h0,         1'b1};
    #1;
    chk("reset_outs", a_stb | a_we | a_rsp_valid | a_rsp_err | (|a_addr) | (|a_wdata) | (|a_rsp_rdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("cmd_ready_after_reset", a_cmd_ready, 1);

    foreach (vecs[i]) run(vecs[i]);

    // Stray acks with nothing outstanding must not create a response.
    sel = 0; ack_en = 0; rd = 32'hBAD0_BAD0; ack_force = 1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_rsp_valid || a_stb || !a_cmd_ready) bad = 1;
    end
    ack_force = 0;
    chk("late_ack_ignored", bad, 0);

    // Response back-pressure: rsp held, new command refused until consumed.
    delay = 0; ack_en = 1; rd = 32'h0000_0055;
    @(negedge clk);
    cmd_valid = 1; cmd_we = 0; cmd_addr = 8'h30;
    @(negedge clk);
    cmd_we = 1; cmd_addr = 8'h31; cmd_wdata = 32'h0000_0077;
    @(negedge clk);
    bad = 0;
    repeat (10) begin
      if (!a_rsp_valid || a_rsp_rdata !== 32'h55 || a_rsp_err || a_cmd_ready || a_stb) bad = 1;
      @(negedge clk);
    end
    chk("rsp_hold_stable", bad, 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("hold_release_idle", {a_cmd_ready, a_stb, a_rsp_valid}, 3'b100);
    @(negedge clk);
    cmd_valid = 0;
    chk("next_cmd_stb", a_stb, 1);
    chk("next_cmd_addr", a_addr, 8'h31);
    chk("next_cmd_wdata", a_wdata, 32'h77);
    @(negedge clk);
    chk("next_cmd_rsp", {a_rsp_valid, a_rsp_err}, 2'b10);
    chk("next_cmd_rdata", a_rsp_rdata, 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;

    // Asynchronous reset in the middle of an access.
    ack_en = 0;
    cmd_valid = 1; cmd_we = 0; cmd_addr = 8'h40;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    chk("pre_reset_stb", a_stb, 1);
    rst_n = 0;
    #1;
    chk("async_reset_stb", a_stb, 0);
    chk("async_reset_rsp", a_rsp_valid, 0);
    @(negedge clk);
    rst_n = 1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_rsp_valid || a_stb || !a_cmd_ready) bad = 1;
    end
    chk("no_rsp_after_reset", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
